// File: rtl/seq_detect_sched_pkg.sv
// Shared types and constants for the time-shared serial pattern detector.
// Context width is fixed here; MAX_LEN on the top must not exceed CTX_HIST_W.
package seq_detect_pkg;

    function automatic int unsigned clog2w(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

    localparam logic [3:0]  DEF_PATTERN = 4'b1011;
    localparam int unsigned DEF_LEN     = 4;
    localparam int unsigned CTX_HIST_W  = 8;
    localparam int unsigned CTX_SEEN_W  = clog2w(CTX_HIST_W + 1);

    typedef struct packed {
        logic [CTX_HIST_W-1:0] hist;
        logic [CTX_SEEN_W-1:0] seen;
    } ctx_t;

endpackage

// File: rtl/seq_detect_sched_if.sv
// Request/grant and match-report bundle between serial sources and the detector.
interface seq_detect_sched_if #(
    parameter int unsigned NCH = 4
) ();
    localparam int unsigned CH_W = seq_detect_pkg::clog2w(NCH);

    logic [NCH-1:0]  req_valid;
    logic [NCH-1:0]  req_bit;
    logic [NCH-1:0]  req_ready;
    logic            found_valid;
    logic [CH_W-1:0] found_ch;

    modport master (
        output req_valid, req_bit,
        input  req_ready, found_valid, found_ch
    );

    modport slave (
        input  req_valid, req_bit,
        output req_ready, found_valid, found_ch
    );
endinterface

// File: rtl/seq_detect_sched_rr_arbiter.sv
// Purely combinational round-robin picker: first request at or above ptr_i, wrapping.
module rr_arbiter
    import seq_detect_pkg::*;
#(
    parameter int unsigned NCH = 4
) (
    input  logic [NCH-1:0]           req_i,
    input  logic [clog2w(NCH)-1:0]   ptr_i,
    output logic [NCH-1:0]           gnt_c_o,
    output logic [clog2w(NCH)-1:0]   idx_c_o,
    output logic                     any_c_o
);
    localparam int unsigned CH_W = clog2w(NCH);

    logic [CH_W-1:0] cand;

    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        any_c_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = CH_W'((32'(ptr_i) + k) % NCH);
            if (!any_c_o && req_i[cand]) begin
                any_c_o       = 1'b1;
                idx_c_o       = cand;
                gnt_c_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// One pattern-match engine time-shared across NCH serial streams with per-channel context.
// Optional per-channel match counters are built when SEQDET_MATCH_COUNT_EN is defined.
module seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned MAX_LEN = 8
) (
    input  logic                           clk,
    input  logic                           res,
    seq_detect_sched_if.slave              bus,
    input  logic                           cfg_we,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [clog2w(MAX_LEN+1)-1:0]   cfg_len,
`ifdef SEQDET_MATCH_COUNT_EN
    input  logic [clog2w(NCH)-1:0]         cnt_sel,
    output logic [7:0]                     cnt_val,
`endif
    output logic                           busy
);
    localparam int unsigned CH_W  = clog2w(NCH);
    localparam int unsigned LEN_W = clog2w(MAX_LEN + 1);

    ctx_t               ctx_q [NCH];
    ctx_t               ctx_d [NCH];
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               found_valid_q, found_valid_d;
    logic [CH_W-1:0]    found_ch_q, found_ch_d;

    logic [NCH-1:0]     req_c;
    logic [NCH-1:0]     gnt_c;
    logic [CH_W-1:0]    gnt_idx_c;
    logic               gnt_any_c;

    // Config and reset both starve the arbiter for that cycle
    assign req_c = bus.req_valid & {NCH{~(res | cfg_we)}};

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req_i   (req_c),
        .ptr_i   (rr_ptr_q),
        .gnt_c_o (gnt_c),
        .idx_c_o (gnt_idx_c),
        .any_c_o (gnt_any_c)
    );

    ctx_t               cur_c;
    logic [MAX_LEN-1:0] hist_new_c;
    logic [LEN_W-1:0]   seen_old_c, seen_new_c;
    logic [MAX_LEN-1:0] mask_c;
    logic               match_c;
    logic               cfg_acc_c;
    logic [LEN_W-1:0]   cfg_len_eff_c;

    // Restore granted channel's context, advance it by one bit, compare
    always_comb begin
        cur_c      = ctx_q[gnt_idx_c];
        hist_new_c = (MAX_LEN'(cur_c.hist) << 1) | MAX_LEN'(bus.req_bit[gnt_idx_c]);
        seen_old_c = LEN_W'(cur_c.seen);
        seen_new_c = (seen_old_c >= len_q) ? len_q : seen_old_c + LEN_W'(1);
        mask_c     = ~({MAX_LEN{1'b1}} << len_q);
        match_c    = gnt_any_c && (seen_new_c == len_q)
                     && (((hist_new_c ^ pattern_q) & mask_c) == '0);
    end

    assign cfg_acc_c     = cfg_we && (cfg_len != '0);
    assign cfg_len_eff_c = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

    always_comb begin
        ctx_d         = ctx_q;
        pattern_d     = pattern_q;
        len_d         = len_q;
        rr_ptr_d      = rr_ptr_q;
        found_valid_d = match_c;
        found_ch_d    = match_c ? gnt_idx_c : found_ch_q;
        if (cfg_acc_c) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len_eff_c;
            for (int unsigned k = 0; k < NCH; k++) ctx_d[k] = '0;
        end else if (gnt_any_c) begin
            ctx_d[gnt_idx_c].hist = CTX_HIST_W'(hist_new_c);
            ctx_d[gnt_idx_c].seen = CTX_SEEN_W'(seen_new_c);
            rr_ptr_d = (gnt_idx_c == CH_W'(NCH - 1)) ? '0 : gnt_idx_c + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            for (int unsigned k = 0; k < NCH; k++) ctx_q[k] <= '0;
            pattern_q     <= MAX_LEN'(DEF_PATTERN);
            len_q         <= LEN_W'(DEF_LEN);
            rr_ptr_q      <= '0;
            found_valid_q <= 1'b0;
            found_ch_q    <= '0;
        end else begin
            ctx_q         <= ctx_d;
            pattern_q     <= pattern_d;
            len_q         <= len_d;
            rr_ptr_q      <= rr_ptr_d;
            found_valid_q <= found_valid_d;
            found_ch_q    <= found_ch_d;
        end
    end

    assign bus.req_ready   = gnt_c;
    assign bus.found_valid = found_valid_q;
    assign bus.found_ch    = found_ch_q;
    assign busy            = (|bus.req_valid) | found_valid_q;

`ifdef SEQDET_MATCH_COUNT_EN
    logic [7:0] cnt_q [NCH];
    logic [7:0] cnt_d [NCH];
    logic [7:0] cnt_val_q, cnt_val_d;

    // Saturating per-channel match tally with a registered read port
    always_comb begin
        cnt_d     = cnt_q;
        cnt_val_d = (32'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : 8'd0;
        if (cfg_acc_c) begin
            for (int unsigned k = 0; k < NCH; k++) cnt_d[k] = '0;
        end else if (match_c && (cnt_q[gnt_idx_c] != 8'hFF)) begin
            cnt_d[gnt_idx_c] = cnt_q[gnt_idx_c] + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            for (int unsigned k = 0; k < NCH; k++) cnt_q[k] <= '0;
            cnt_val_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            cnt_val_q <= cnt_val_d;
        end
    end

    assign cnt_val = cnt_val_q;
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed self-checking bench for seq_detect_sched (NCH=4, MAX_LEN=8).
module tb_seq_detect_sched;
    localparam int unsigned NCH     = 4;
    localparam int unsigned MAX_LEN = 8;

    logic       clk = 1'b0;
    logic       res;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       busy;
`ifdef SEQDET_MATCH_COUNT_EN
    logic [1:0] cnt_sel;
    logic [7:0] cnt_val;
`endif

    int checks = 0;
    int fails  = 0;

    seq_detect_sched_if #(.NCH(NCH)) bus ();

    seq_detect_sched #(.NCH(NCH), .MAX_LEN(MAX_LEN)) dut (
        .clk         (clk),
        .res         (res),
        .bus         (bus),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
`ifdef SEQDET_MATCH_COUNT_EN
        .cnt_sel     (cnt_sel),
        .cnt_val     (cnt_val),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [3:0] v, input logic [3:0] b);
        bus.req_valid = v;
        bus.req_bit   = b;
        #1;
    endtask

    task automatic send(input int ch, input logic b);
        drive(4'(1 << ch), b ? 4'(1 << ch) : 4'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res    = 1'b1;
        cfg_we = 1'b0;
        drive(4'h0, 4'h0);
        tick();
        res = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] s;
        logic       expf;
        s      = 4'b1011;
        res    = 1'b1;
        cfg_we = 1'b0;
        drive(4'hF, 4'hF);
        checks++;
        if (bus.req_ready !== 4'h0) begin
            fails++; $display("FAIL reset_ready: got %h expected %h", bus.req_ready, 4'h0);
        end
        tick(); tick();
        checks++;
        if (bus.found_valid !== 1'b0) begin
            fails++; $display("FAIL reset_found_valid: got %b expected 0", bus.found_valid);
        end
        checks++;
        if (bus.found_ch !== 2'd0) begin
            fails++; $display("FAIL reset_found_ch: got %0d expected 0", bus.found_ch);
        end
        res = 1'b0;
        drive(4'h0, 4'h0);
        checks++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        for (int k = 0; k < 4; k++) begin
            send(0, s[3-k]);
            checks++;
            if (bus.req_ready !== 4'b0001) begin
                fails++; $display("FAIL default_ready k=%0d: got %h expected 1", k, bus.req_ready);
            end
            tick();
            expf = (k == 3);
            checks++;
            if (bus.found_valid !== expf) begin
                fails++; $display("FAIL default_found k=%0d: got %b expected %b", k, bus.found_valid, expf);
            end
            if (expf) begin
                checks++;
                if (bus.found_ch !== 2'd0) begin
                    fails++; $display("FAIL default_ch: got %0d expected 0", bus.found_ch);
                end
            end
        end
        drive(4'h0, 4'h0);
        tick();
        checks++;
        if (bus.found_valid !== 1'b0) begin
            fails++; $display("FAIL default_pulse_len: got %b expected 0", bus.found_valid);
        end
`ifdef SEQDET_MATCH_COUNT_EN
        checks++;
        if (cnt_val !== 8'd1) begin
            fails++; $display("FAIL cnt_val_ch0: got %0d expected 1", cnt_val);
        end
`endif
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        logic [6:0] e;
        s = 7'b1011011;
        e = 7'b0001001;
        for (int k = 0; k < 7; k++) begin
            send(1, s[6-k]);
            checks++;
            if (bus.req_ready !== 4'b0010) begin
                fails++; $display("FAIL overlap_ready k=%0d: got %h expected 2", k, bus.req_ready);
            end
            tick();
            checks++;
            if (bus.found_valid !== e[6-k]) begin
                fails++; $display("FAIL overlap_found k=%0d: got %b expected %b", k, bus.found_valid, e[6-k]);
            end
            if (e[6-k]) begin
                checks++;
                if (bus.found_ch !== 2'd1) begin
                    fails++; $display("FAIL overlap_ch k=%0d: got %0d expected 1", k, bus.found_ch);
                end
            end
        end
    endtask

    task automatic test_interleave();
        logic [3:0] s;
        logic       b;
        logic       expf;
        s = 4'b1011;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            b = s[3 - c/4];
            drive(4'hF, {4{b}});
            checks++;
            if (bus.req_ready !== 4'(1 << (c % 4))) begin
                fails++; $display("FAIL rr_ready c=%0d: got %h expected %h", c, bus.req_ready, 4'(1 << (c % 4)));
            end
            checks++;
            if (busy !== 1'b1) begin
                fails++; $display("FAIL rr_busy c=%0d: got %b expected 1", c, busy);
            end
            tick();
            expf = (c >= 12);
            checks++;
            if (bus.found_valid !== expf) begin
                fails++; $display("FAIL rr_found c=%0d: got %b expected %b", c, bus.found_valid, expf);
            end
            if (expf) begin
                checks++;
                if (bus.found_ch !== 2'(c - 12)) begin
                    fails++; $display("FAIL rr_ch c=%0d: got %0d expected %0d", c, bus.found_ch, c - 12);
                end
            end
        end
        drive(4'h0, 4'h0);
        checks++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL busy_pending: got %b expected 1", busy);
        end
        tick();
        checks++;
        if (bus.found_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rr_idle: got found=%b busy=%b expected 0 0", bus.found_valid, busy);
        end
    endtask

    task automatic test_arb_ptr();
        do_reset();
        send(1, 1'b0);
        tick();
        drive(4'h0, 4'h0);
        tick();
        drive(4'b1001, 4'h0);
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            fails++; $display("FAIL ptr_hold: got %h expected 8", bus.req_ready);
        end
        tick();
        drive(4'b1001, 4'h0);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            fails++; $display("FAIL ptr_wrap: got %h expected 1", bus.req_ready);
        end
        tick();
        drive(4'h0, 4'h0);
    endtask

    task automatic test_reconfig();
        logic [2:0] p;
        logic [8:0] s;
        logic [8:0] e;
        p = 3'b101;
        s = 9'b101101011;
        e = 9'b000010000;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send(2, p[2-k]);
            tick();
        end
        cfg_we      = 1'b1;
        cfg_pattern = 8'b0000_0110;
        cfg_len     = 4'd3;
        drive(4'b0100, 4'b0100);
        checks++;
        if (bus.req_ready !== 4'h0) begin
            fails++; $display("FAIL cfg_ready: got %h expected 0", bus.req_ready);
        end
        tick();
        cfg_we = 1'b0;
        checks++;
        if (bus.found_valid !== 1'b0) begin
            fails++; $display("FAIL cfg_found: got %b expected 0", bus.found_valid);
        end
        for (int k = 0; k < 9; k++) begin
            send(2, s[8-k]);
            tick();
            checks++;
            if (bus.found_valid !== e[8-k]) begin
                fails++; $display("FAIL reconf_found k=%0d: got %b expected %b", k, bus.found_valid, e[8-k]);
            end
            if (e[8-k]) begin
                checks++;
                if (bus.found_ch !== 2'd2) begin
                    fails++; $display("FAIL reconf_ch: got %0d expected 2", bus.found_ch);
                end
            end
        end
        drive(4'h0, 4'h0);
    endtask

    task automatic test_edge_cfg();
        logic [3:0] s;
        logic [3:0] e;
        logic [8:0] s8;
        logic [8:0] e8;
        s  = 4'b0110;
        e  = 4'b1001;
        s8 = 9'b101001011;
        e8 = 9'b000000010;
        send(0, 1'b1); tick();
        send(0, 1'b1); tick();
        cfg_we      = 1'b1;
        cfg_pattern = 8'b0000_1011;
        cfg_len     = 4'd0;
        drive(4'b0001, 4'h0);
        checks++;
        if (bus.req_ready !== 4'h0) begin
            fails++; $display("FAIL len0_ready: got %h expected 0", bus.req_ready);
        end
        tick();
        cfg_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(0, s[3-k]);
            tick();
            checks++;
            if (bus.found_valid !== e[3-k]) begin
                fails++; $display("FAIL len0_found k=%0d: got %b expected %b", k, bus.found_valid, e[3-k]);
            end
        end
        cfg_we      = 1'b1;
        cfg_pattern = 8'b1010_0101;
        cfg_len     = 4'd15;
        drive(4'b0001, 4'b0001);
        checks++;
        if (bus.found_valid !== 1'b1 || bus.req_ready !== 4'h0) begin
            fails++; $display("FAIL inflight: got found=%b ready=%h expected 1 0", bus.found_valid, bus.req_ready);
        end
        tick();
        cfg_we = 1'b0;
        checks++;
        if (bus.found_valid !== 1'b0) begin
            fails++; $display("FAIL inflight_end: got %b expected 0", bus.found_valid);
        end
        for (int k = 0; k < 9; k++) begin
            send(0, s8[8-k]);
            tick();
            checks++;
            if (bus.found_valid !== e8[8-k]) begin
                fails++; $display("FAIL clamp_found k=%0d: got %b expected %b", k, bus.found_valid, e8[8-k]);
            end
        end
        drive(4'h0, 4'h0);
    endtask

    task automatic test_sync_reset();
        logic [2:0] p;
        logic [4:0] s;
        logic [4:0] e;
        p = 3'b101;
        s = 5'b11011;
        e = 5'b00001;
        for (int k = 0; k < 3; k++) begin
            send(3, p[2-k]);
            tick();
        end
        res = 1'b1;
        drive(4'b1000, 4'b1000);
        checks++;
        if (bus.req_ready !== 4'h0) begin
            fails++; $display("FAIL midres_ready: got %h expected 0", bus.req_ready);
        end
        tick();
        res = 1'b0;
        checks++;
        if (bus.found_valid !== 1'b0) begin
            fails++; $display("FAIL midres_found: got %b expected 0", bus.found_valid);
        end
        for (int k = 0; k < 5; k++) begin
            send(3, s[4-k]);
            tick();
            checks++;
            if (bus.found_valid !== e[4-k]) begin
                fails++; $display("FAIL midres_seq k=%0d: got %b expected %b", k, bus.found_valid, e[4-k]);
            end
            if (e[4-k]) begin
                checks++;
                if (bus.found_ch !== 2'd3) begin
                    fails++; $display("FAIL midres_ch: got %0d expected 3", bus.found_ch);
                end
            end
        end
        drive(4'h0, 4'h0);
    endtask

    initial begin
        res           = 1'b1;
        cfg_we        = 1'b0;
        cfg_pattern   = 8'h00;
        cfg_len       = 4'd0;
        bus.req_valid = 4'h0;
        bus.req_bit   = 4'h0;
`ifdef SEQDET_MATCH_COUNT_EN
        cnt_sel = 2'd0;
`endif
        tick();
        test_reset();
        test_overlap();
        test_interleave();
        test_arb_ptr();
        test_reconfig();
        test_edge_cfg();
        test_sync_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
